pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum MEM_WAIT cycles before the timeout error is raised.
REQ-002 Parameter CNTW, default 16: width of the stall performance counter.
REQ-003 Clk  in  1  single clock; all state updates on rising edge.
REQ-004 Rst  in  1  reset, asynchronous, active-low.
REQ-005 IDEX_MemRead  in  1  the instruction in EX is a load.
REQ-006 IDEX_Rt  in  5  load destination register in EX.
REQ-007 IFID_Rs, IFID_Rt  in  5 each  source registers of the instruction in ID.
REQ-008 EXMEM_Branch, EXMEM_Zero  in  1 each  branch and zero flags at the EX/MEM output.
REQ-009 EXMEM_MemRead, EXMEM_MemWrite  in  1 each  memory access in the MEM stage.
REQ-010 Mem_ready  in  1  data memory has completed the current access.
REQ-011 Mem_req  out  1  data memory access request.
REQ-012 PCWrite, IFID_Write  out  1 each  enables for the PC and IF/ID updates.
REQ-013 IDEX_Hold, EXMEM_Hold  out  1 each  hold ID/EX and EX/MEM contents.
REQ-014 IFID_Flush, IDEX_Flush, EXMEM_Flush  out  1 each  load a bubble (all controls 0) into the register on the next edge.
REQ-015 Mem_timeout  out  1  sticky error flag.
REQ-016 State  out  2  FSM state: 00 RUN, 01 MEM_WAIT, 10 ERROR.
REQ-017 Stall_count  out  CNTW  count of cycles with PCWrite=0.

Function
REQ-018 The FSM SHALL have three states: RUN, MEM_WAIT and ERROR. Outputs SHALL be combinational from State and the inputs. Default output values: PCWrite=1, IFID_Write=1, all Hold, Flush and Mem_req outputs 0.
REQ-019 Mem_req SHALL equal (EXMEM_MemRead|EXMEM_MemWrite) in RUN and in MEM_WAIT, and SHALL be 0 in ERROR.
REQ-020 RUN with Mem_req=1 and Mem_ready=0 SHALL freeze the pipeline: PCWrite=0, IFID_Write=0, IDEX_Hold=1, EXMEM_Hold=1, all Flush=0. The next state SHALL be MEM_WAIT and the wait counter SHALL load 1.
REQ-021 RUN with Mem_ready=1, or with no memory access, SHALL NOT stall for memory (zero added latency).
REQ-022 MEM_WAIT with Mem_ready=0 SHALL keep the freeze and increment the wait counter. When the counter equals TIMEOUT, the next state SHALL be ERROR.
REQ-023 MEM_WAIT with Mem_ready=1 SHALL release the freeze in the same cycle and return to RUN. Branch and load-use rules SHALL apply in that cycle.
REQ-024 Branch taken (EXMEM_Branch & EXMEM_Zero) outside a freeze SHALL assert IFID_Flush, IDEX_Flush and EXMEM_Flush for exactly that cycle. PCWrite SHALL stay 1.
REQ-025 Load-use hazard: IDEX_MemRead & IDEX_Rt!=0 & (IDEX_Rt==IFID_Rs | IDEX_Rt==IFID_Rt), outside a freeze and with no branch taken. It SHALL give PCWrite=0, IFID_Write=0 and IDEX_Flush=1 for one cycle.
REQ-026 Priority SHALL be: memory freeze, then branch flush, then load-use. A branch taken SHALL suppress the load-use stall.
REQ-027 A branch taken while frozen SHALL be deferred, not lost, because EX/MEM is held. It SHALL take effect in the release cycle.
REQ-028 ERROR SHALL be terminal until reset: Mem_timeout=1, PCWrite=0, IFID_Write=0, both Holds=1, all Flushes=0.
REQ-029 Stall_count SHALL increment on every edge where PCWrite=0 and SHALL saturate at all-ones.
REQ-030 Register R0 SHALL never create a hazard.

Reset
REQ-031 Rst=0 SHALL asynchronously set State=RUN, the wait counter=0, Stall_count=0 and Mem_timeout=0.
REQ-032 While Rst=0: PCWrite=0, IFID_Write=0, Mem_req=0, all Holds and Flushes 0.
REQ-033 Reset asserted mid-MEM_WAIT or in ERROR SHALL abandon the access. Operation SHALL resume in RUN after deassertion, with no pending flush.

Verification
REQ-034 Load-use: IDEX_MemRead=1, IDEX_Rt=8, IFID_Rs=8 -> one cycle with PCWrite=0 and IDEX_Flush=1, then Stall_count=1.
REQ-035 R0 case: same stimulus with IDEX_Rt=0 -> no stall, Stall_count=0.
REQ-036 Memory wait: EXMEM_MemRead=1 with Mem_ready low for 3 cycles, then high -> Holds asserted 3 cycles, released in the ready cycle, State returns to 00, Stall_count=3.
REQ-037 Branch plus load-use in the same cycle -> all three Flushes=1, PCWrite=1, no stall.
REQ-038 Timeout with TIMEOUT=4: Mem_ready held 0 -> State=10 after 4 wait cycles, Mem_timeout=1 and Mem_req=0. Pulsing Rst low then returns State=00 and Mem_timeout=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller: memory-wait freeze with timeout, branch flush, load-use stall.
// Outputs are combinational from state and inputs; next-state and counters update on Clk.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNTW    = 16
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            IDEX_MemRead,
  input  logic [4:0]      IDEX_Rt,
  input  logic [4:0]      IFID_Rs,
  input  logic [4:0]      IFID_Rt,
  input  logic            EXMEM_Branch,
  input  logic            EXMEM_Zero,
  input  logic            EXMEM_MemRead,
  input  logic            EXMEM_MemWrite,
  input  logic            Mem_ready,
  output logic            Mem_req,
  output logic            PCWrite,
  output logic            IFID_Write,
  output logic            IDEX_Hold,
  output logic            EXMEM_Hold,
  output logic            IFID_Flush,
  output logic            IDEX_Flush,
  output logic            EXMEM_Flush,
  output logic            Mem_timeout,
  output logic [1:0]      State,
  output logic [CNTW-1:0] Stall_count
);

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_MEM_WAIT = 2'b01;
  localparam logic [1:0] ST_ERROR    = 2'b10;

  localparam int WCW = $clog2(TIMEOUT + 1);

  logic [1:0]      state_q, state_d;
  logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
  logic            timeout_q, timeout_d;
  logic            branch_pend_q, branch_pend_d;

  logic mem_access;
  logic branch_taken;
  logic load_use;
  logic freeze;
  logic in_error;

  logic mem_req;
  logic pc_write;
  logic ifid_write;
  logic idex_hold;
  logic exmem_hold;
  logic ifid_flush;
  logic idex_flush;
  logic exmem_flush;

  assign mem_access   = EXMEM_MemRead | EXMEM_MemWrite;
  assign branch_taken = EXMEM_Branch & EXMEM_Zero;
  // R0 is hardwired zero, so a load targeting it can never feed a consumer.
  assign load_use     = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                        ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));

  // State transitions and the memory-wait counter.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    freeze     = 1'b0;
    in_error   = 1'b0;
    mem_req    = 1'b0;
    case (state_q)
      ST_RUN: begin
        mem_req = mem_access;
        if (mem_access && !Mem_ready) begin
          freeze     = 1'b1;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WCW'(1);
        end
      end
      ST_MEM_WAIT: begin
        mem_req = mem_access;
        if (!Mem_ready) begin
          freeze = 1'b1;
          if (wait_cnt_q == WCW'(TIMEOUT)) begin
            state_d   = ST_ERROR;
            timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WCW'(1);
          end
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end
      ST_ERROR: begin
        in_error = 1'b1;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Pipeline control with priority freeze > branch > load-use.
  always_comb begin
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    idex_hold     = 1'b0;
    exmem_hold    = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    branch_pend_d = 1'b0;
    if (freeze || in_error) begin
      pc_write      = 1'b0;
      ifid_write    = 1'b0;
      idex_hold     = 1'b1;
      exmem_hold    = 1'b1;
      // A branch seen while EX/MEM is held is remembered and resolved on release.
      branch_pend_d = branch_pend_q | (freeze & branch_taken);
    end else if (branch_taken || branch_pend_q) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      timeout_q     <= 1'b0;
      branch_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      timeout_q     <= timeout_d;
      branch_pend_q <= branch_pend_d;
    end
  end

  // Everything is quiesced while reset is held, including the PC enable.
  assign Mem_req     = Rst & mem_req;
  assign PCWrite     = Rst & pc_write;
  assign IFID_Write  = Rst & ifid_write;
  assign IDEX_Hold   = Rst & idex_hold;
  assign EXMEM_Hold  = Rst & exmem_hold;
  assign IFID_Flush  = Rst & ifid_flush;
  assign IDEX_Flush  = Rst & idex_flush;
  assign EXMEM_Flush = Rst & exmem_flush;
  assign Mem_timeout = timeout_q;
  assign State       = state_q;
  assign Stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with TIMEOUT=4 and a 4-bit stall counter.
module tb_pipeline_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       IDEX_MemRead;
  logic [4:0] IDEX_Rt, IFID_Rs, IFID_Rt;
  logic       EXMEM_Branch, EXMEM_Zero, EXMEM_MemRead, EXMEM_MemWrite, Mem_ready;
  logic       Mem_req, PCWrite, IFID_Write, IDEX_Hold, EXMEM_Hold;
  logic       IFID_Flush, IDEX_Flush, EXMEM_Flush, Mem_timeout;
  logic [1:0] State;
  logic [3:0] Stall_count;

  int checks   = 0;
  int failures = 0;

  pipeline_hazard_ctrl #(.TIMEOUT(4), .CNTW(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
    .EXMEM_Branch(EXMEM_Branch), .EXMEM_Zero(EXMEM_Zero),
    .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemWrite(EXMEM_MemWrite),
    .Mem_ready(Mem_ready), .Mem_req(Mem_req),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write),
    .IDEX_Hold(IDEX_Hold), .EXMEM_Hold(EXMEM_Hold),
    .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush), .EXMEM_Flush(EXMEM_Flush),
    .Mem_timeout(Mem_timeout), .State(State), .Stall_count(Stall_count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    IDEX_MemRead = 0; IDEX_Rt = 0; IFID_Rs = 0; IFID_Rt = 0;
    EXMEM_Branch = 0; EXMEM_Zero = 0; EXMEM_MemRead = 0; EXMEM_MemWrite = 0;
    Mem_ready = 0;
  endtask

  // Packs {PCWrite, IFID_Write, IDEX_Hold, EXMEM_Hold, IFID_Flush, IDEX_Flush, EXMEM_Flush, Mem_req}
  function automatic logic [7:0] ctl();
    return {PCWrite, IFID_Write, IDEX_Hold, EXMEM_Hold,
            IFID_Flush, IDEX_Flush, EXMEM_Flush, Mem_req};
  endfunction

  initial begin
    Rst = 1'b0;
    clr();
    EXMEM_MemRead = 1;
    #2;
    chk("reset_ctl", ctl(), 8'b0000_0000);
    chk("reset_state", State, 2'b00);
    chk("reset_cnt", Stall_count, 4'd0);
    chk("reset_tmo", Mem_timeout, 1'b0);
    clr();
    #10 Rst = 1'b1;
    #1;
    chk("idle_ctl", ctl(), 8'b1100_0000);

    // R0 destination never stalls
    IDEX_MemRead = 1; IDEX_Rt = 0; IFID_Rs = 0; IFID_Rt = 0;
    #1 chk("r0_ctl", ctl(), 8'b1100_0000);
    tick();
    chk("r0_cnt", Stall_count, 4'd0);

    // Load-use via Rs
    IDEX_MemRead = 1; IDEX_Rt = 8; IFID_Rs = 8; IFID_Rt = 3;
    #1 chk("lu_rs_ctl", ctl(), 8'b0000_0100);
    tick();
    clr();
    #1 chk("lu_rs_cnt", Stall_count, 4'd1);
    chk("lu_after_ctl", ctl(), 8'b1100_0000);

    // Load-use via Rt
    IDEX_MemRead = 1; IDEX_Rt = 17; IFID_Rs = 2; IFID_Rt = 17;
    #1 chk("lu_rt_ctl", ctl(), 8'b0000_0100);
    tick();
    clr();
    #1 chk("lu_rt_cnt", Stall_count, 4'd2);

    // Matching register but not a load
    IDEX_MemRead = 0; IDEX_Rt = 8; IFID_Rs = 8;
    #1 chk("noload_ctl", ctl(), 8'b1100_0000);
    tick();
    clr();

    // Memory ready immediately: no stall
    EXMEM_MemRead = 1; Mem_ready = 1;
    #1 chk("memrdy_ctl", ctl(), 8'b1100_0001);
    tick();
    chk("memrdy_state", State, 2'b00);
    chk("memrdy_cnt", Stall_count, 4'd2);

    // Memory wait: three frozen cycles then release
    clr();
    EXMEM_MemRead = 1; Mem_ready = 0;
    #1 chk("mw_c0_ctl", ctl(), 8'b0011_0001);
    tick();
    chk("mw_c1_state", State, 2'b01);
    chk("mw_c1_ctl", ctl(), 8'b0011_0001);
    tick();
    chk("mw_c2_ctl", ctl(), 8'b0011_0001);
    tick();
    Mem_ready = 1;
    #1 chk("mw_rel_ctl", ctl(), 8'b1100_0001);
    chk("mw_rel_state", State, 2'b01);
    tick();
    chk("mw_end_state", State, 2'b00);
    chk("mw_end_cnt", Stall_count, 4'd5);
    clr();

    // Branch taken while frozen takes effect on release
    EXMEM_MemWrite = 1; EXMEM_Branch = 1; EXMEM_Zero = 1; Mem_ready = 0;
    #1 chk("bfz_ctl", ctl(), 8'b0011_0001);
    tick();
    Mem_ready = 1;
    #1 chk("bfz_rel_ctl", ctl(), 8'b1100_1111);
    tick();
    clr();
    #1 chk("bfz_after_ctl", ctl(), 8'b1100_0000);
    chk("bfz_cnt", Stall_count, 4'd6);

    // Branch plus load-use: branch wins, no stall
    EXMEM_Branch = 1; EXMEM_Zero = 1; IDEX_MemRead = 1; IDEX_Rt = 8; IFID_Rs = 8;
    #1 chk("br_lu_ctl", ctl(), 8'b1100_1110);
    tick();
    chk("br_lu_cnt", Stall_count, 4'd6);

    // Branch not taken: load-use applies
    EXMEM_Zero = 0;
    #1 chk("bnt_lu_ctl", ctl(), 8'b0000_0100);
    tick();
    clr();
    chk("bnt_lu_cnt", Stall_count, 4'd7);

    // Timeout: RUN freeze then four MEM_WAIT cycles
    EXMEM_MemRead = 1; Mem_ready = 0;
    #1;
    for (int i = 0; i < 4; i++) tick();
    chk("tmo_pre_state", State, 2'b01);
    chk("tmo_pre_flag", Mem_timeout, 1'b0);
    tick();
    EXMEM_Branch = 1; EXMEM_Zero = 1;
    #1 chk("tmo_state", State, 2'b10);
    chk("tmo_flag", Mem_timeout, 1'b1);
    chk("tmo_ctl", ctl(), 8'b0011_0000);
    chk("tmo_cnt", Stall_count, 4'd12);
    Mem_ready = 1;
    for (int i = 0; i < 10; i++) tick();
    chk("err_terminal", State, 2'b10);
    chk("cnt_saturate", Stall_count, 4'hF);

    // Reset from ERROR
    #2 Rst = 1'b0;
    #1 chk("rst_err_state", State, 2'b00);
    chk("rst_err_flag", Mem_timeout, 1'b0);
    chk("rst_err_cnt", Stall_count, 4'd0);
    chk("rst_err_ctl", ctl(), 8'b0000_0000);
    clr();
    tick();
    Rst = 1'b1;
    #1 chk("rst_err_resume", ctl(), 8'b1100_0000);

    // Reset mid-MEM_WAIT with a deferred branch abandons it
    EXMEM_MemRead = 1; EXMEM_Branch = 1; EXMEM_Zero = 1; Mem_ready = 0;
    tick();
    chk("rst_mw_pre", State, 2'b01);
    #2 Rst = 1'b0;
    #1 chk("rst_mw_state", State, 2'b00);
    clr();
    tick();
    Rst = 1'b1;
    #1 chk("rst_mw_noflush", ctl(), 8'b1100_0000);
    tick();
    chk("rst_mw_run", State, 2'b00);
    chk("rst_mw_cnt", Stall_count, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
